burst_pulser: RTL and testbench
===============================

# burst_pulser

Parametrised multi-channel pulse-train generator, the next generation of the single-shot pulser array. Each channel emits a burst of COUNT pulses of programmable delay, width and period after a shared trigger. Configuration uses shadow registers behind a simple synchronous register port, which the SPI command decoder drives. Timing parameters are latched into active copies at trigger, so reprogramming never disturbs a running burst.

## Interface
Parameters:
- N_CH, 8, number of channels (1..32)
- CW, 32, width of delay/width/period counters
- RW, 16, width of burst repeat count
- CHW, $clog2(N_CH) (min 1), channel-select width (derived)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write strobe, one write per asserted cycle
- cfg_ch  in  CHW  channel select
- cfg_reg  in  3  register select: 0 DELAY, 1 WIDTH, 2 PERIOD, 3 COUNT, 4 ENABLE (global), 5 STATUS (RO), 6 MISSED (RO, write clears)
- cfg_wdata  in  CW  write data (COUNT uses [RW-1:0], ENABLE uses [N_CH-1:0])
- cfg_rdata  out  CW  combinational read of addressed register, zero-extended
- trig_in  in  1  trigger, sampled each edge (caller supplies edge-detected pulse)
- abort  in  1  synchronous abort of all channels
- pulse_out  out  N_CH  registered channel outputs
- busy  out  1  any latched channel running
- done  out  1  one-cycle pulse when a burst completes normally

## Operation
- Shadow reset values: DELAY=100, WIDTH=100, PERIOD=200, COUNT=1, ENABLE=0, MISSED=0. cfg_ch >= N_CH: writes ignored, reads return 0.
- Trigger accepted at edge E0 when trig_in=1, busy=0, abort=0. At E0 all shadows copy to active registers; channel starts only if ENABLE bit set and WIDTH!=0.
- Trigger with busy=1: ignored, MISSED increments (saturates at all ones).
- Per-channel FSM: IDLE -> WAIT (delay) -> HIGH -> LOW -> HIGH ... -> IDLE. LOW entered after each pulse except the last; after last HIGH the channel goes directly to IDLE.
- Effective period P = max(PERIOD, WIDTH+1), computed in CW+1 bits (no overflow at WIDTH=2^CW-1). LOW lasts P-WIDTH cycles.
- COUNT=0 treated as 1. Pulse counter RW bits, no wrap.
- STATUS = per-channel running bits [N_CH-1:0].
- busy = OR of running bits. done asserts for one cycle on the edge the last running channel returns to IDLE without abort.
- abort: all channels to IDLE, pulse_out=0, busy=0 on the next edge; done not asserted. Abort and trigger on the same edge: abort wins, trigger discarded, MISSED unchanged.
- Write on the same edge as trigger acceptance: active copy takes the old value, shadow takes the new one.
- Reset mid-burst: all outputs and state return to reset values immediately (asynchronous).

## Timing
- Reset values: pulse_out=0, busy=0, done=0, cfg_rdata reflects reset shadows.
- Pulse k (k=0..COUNT-1) is high from the edge E0+DELAY+1+k*P through the edge E0+DELAY+1+k*P+WIDTH (exclusive), i.e. exactly WIDTH cycles. DELAY=0 gives one-cycle latency.
- busy rises on E0 (visible after E0). It falls on the edge the final pulse falls, E0+DELAY+1+(COUNT-1)*P+WIDTH (latest channel). done pulses on that same edge.
- Next trigger is accepted on the first edge where busy=0, at the earliest the cycle after done.
- Register writes take effect on the write edge; reads are same-cycle combinational.
- Channels are mutually cycle-aligned: equal settings give identical pulse_out bits.

## Test plan
- Reset then read all registers -> DELAY=100, WIDTH=100, PERIOD=200, COUNT=1, ENABLE=0; pulse_out=0, busy=0.
- ch0 DELAY=0, WIDTH=3, PERIOD=5, COUNT=3, ENABLE=1, trigger at E0 -> ch0 high edges 1-3, 6-8, 11-13; busy high edges 0-13; done single cycle at edge 14 boundary; other outputs 0.
- ch1 WIDTH=4, PERIOD=2 (P clamps to 5), COUNT=2 -> highs of 4 cycles separated by exactly 1 low cycle.
- Trigger while busy, twice -> no restart, MISSED=2; write MISSED -> 0.
- Mid-burst write DELAY=7 to a running channel -> current burst unchanged; next trigger uses 7.
- abort during HIGH -> pulse_out=0 and busy=0 next edge, no done; abort with simultaneous trig_in -> nothing starts.

Source files
------------

// File: rtl/burst_pulser_if.sv
// Configuration bus between the SPI command decoder and burst_pulser.
// The decoder holds the master side and burst_pulser the slave side.
// Writes are single-cycle strobes. Reads are combinational in the same cycle.
interface burst_pulser_if #(
    parameter int N_CH = 8,
    parameter int CW   = 32,
    parameter int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [2:0]     cfg_reg;
    logic [CW-1:0]  cfg_wdata;
    logic [CW-1:0]  cfg_rdata;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_reg,
        output cfg_wdata,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_reg,
        input  cfg_wdata,
        output cfg_rdata
    );
endinterface

// File: rtl/burst_pulser.sv
// burst_pulser: a multi-channel pulse-train generator.
// After a shared trigger, each enabled channel waits DELAY cycles.
// It then emits COUNT pulses. Each pulse is WIDTH cycles high, and a new
// pulse starts every max(PERIOD, WIDTH+1) cycles.
// Software writes shadow registers. The timing shadows are copied into
// active registers when a trigger is accepted, so reprogramming a channel
// never disturbs a burst that is already running.
// rst is asynchronous and active-low.
module burst_pulser #(
    parameter int N_CH = 8,
    parameter int CW   = 32,
    parameter int RW   = 16,
    parameter int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    burst_pulser_if.slave   cfg,
    input  logic            trig_in,
    input  logic            abort,
    output logic [N_CH-1:0] pulse_out,
    output logic            busy,
    output logic            done
);

    localparam logic [2:0] REG_DELAY  = 3'd0;
    localparam logic [2:0] REG_WIDTH  = 3'd1;
    localparam logic [2:0] REG_PERIOD = 3'd2;
    localparam logic [2:0] REG_COUNT  = 3'd3;
    localparam logic [2:0] REG_ENABLE = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;
    localparam logic [2:0] REG_MISSED = 3'd6;

    localparam logic [CW:0] WIDE_ONE = (CW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HIGH,
        ST_LOW
    } ch_state_t;

    // Shadow registers, written by software.
    logic [CW-1:0]   sh_delay  [N_CH];
    logic [CW-1:0]   sh_width  [N_CH];
    logic [CW-1:0]   sh_period [N_CH];
    logic [RW-1:0]   sh_count  [N_CH];
    logic [N_CH-1:0] enable;
    logic [CW-1:0]   missed;

    // Active copies, latched when a trigger is accepted.
    logic [CW-1:0]   act_width  [N_CH];
    logic [CW-1:0]   act_period [N_CH];

    // Per-channel sequencing state.
    ch_state_t       state [N_CH];
    logic [CW-1:0]   cnt   [N_CH];
    logic [RW-1:0]   rem   [N_CH];

    // Derived per-channel values.
    logic [CW:0]     eff_period [N_CH];
    logic [CW-1:0]   low_len    [N_CH];
    logic [N_CH-1:0] running;
    logic [N_CH-1:0] finishing;

    logic ch_valid;
    logic wr_en;
    logic accept;

    // Channel selects beyond the last channel address nothing.
    // Writes to them are dropped, and reads from them return zero.
    assign ch_valid = (32'(cfg.cfg_ch) < 32'(N_CH));
    assign wr_en    = cfg.cfg_we && ch_valid;

    // A trigger starts a new burst only while every channel is idle and no abort is pending.
    assign busy   = |running;
    assign accept = trig_in && !busy && !abort;

    // Per-channel running/finishing flags and the effective low-phase length.
    // The period is clamped in CW+1 bits so that WIDTH = all-ones cannot overflow.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            running[i]    = (state[i] != ST_IDLE);
            finishing[i]  = (state[i] == ST_HIGH) && (cnt[i] == '0) && (rem[i] == '0);
            eff_period[i] = ({1'b0, act_period[i]} > ({1'b0, act_width[i]} + WIDE_ONE))
                          ? {1'b0, act_period[i]}
                          : ({1'b0, act_width[i]} + WIDE_ONE);
            low_len[i]    = CW'(eff_period[i] - {1'b0, act_width[i]});
        end
    end

    // Same-cycle read of the addressed register, zero-extended to CW bits.
    always_comb begin
        cfg.cfg_rdata = '0;
        if (ch_valid) begin
            case (cfg.cfg_reg)
                REG_DELAY:  cfg.cfg_rdata = sh_delay[cfg.cfg_ch];
                REG_WIDTH:  cfg.cfg_rdata = sh_width[cfg.cfg_ch];
                REG_PERIOD: cfg.cfg_rdata = sh_period[cfg.cfg_ch];
                REG_COUNT:  cfg.cfg_rdata = CW'(sh_count[cfg.cfg_ch]);
                REG_ENABLE: cfg.cfg_rdata = CW'(enable);
                REG_STATUS: cfg.cfg_rdata = CW'(running);
                REG_MISSED: cfg.cfg_rdata = missed;
                default:    cfg.cfg_rdata = '0;
            endcase
        end
    end

    // Shadow register writes and the saturating counter of triggers that arrived while busy.
    // A write to MISSED clears it, and the clear wins over a simultaneous increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                sh_delay[i]  <= CW'(100);
                sh_width[i]  <= CW'(100);
                sh_period[i] <= CW'(200);
                sh_count[i]  <= RW'(1);
            end
            enable <= '0;
            missed <= '0;
        end else begin
            if (wr_en) begin
                case (cfg.cfg_reg)
                    REG_DELAY:  sh_delay[cfg.cfg_ch]  <= cfg.cfg_wdata;
                    REG_WIDTH:  sh_width[cfg.cfg_ch]  <= cfg.cfg_wdata;
                    REG_PERIOD: sh_period[cfg.cfg_ch] <= cfg.cfg_wdata;
                    REG_COUNT:  sh_count[cfg.cfg_ch]  <= cfg.cfg_wdata[RW-1:0];
                    REG_ENABLE: enable                <= cfg.cfg_wdata[N_CH-1:0];
                    default:    ;
                endcase
            end
            if (wr_en && (cfg.cfg_reg == REG_MISSED)) begin
                missed <= '0;
            end else if (trig_in && busy && !abort && (missed != '1)) begin
                missed <= missed + CW'(1);
            end
        end
    end

    // Channel sequencers, all stepped together so that equal settings stay cycle-aligned.
    // WAIT counts down DELAY. HIGH counts down WIDTH. LOW counts down the period minus WIDTH.
    // After the last pulse, a channel leaves HIGH directly for IDLE.
    // done fires on the edge where the last running channel finishes normally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i]      <= ST_IDLE;
                cnt[i]        <= '0;
                rem[i]        <= '0;
                act_width[i]  <= '0;
                act_period[i] <= '0;
            end
            pulse_out <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                for (int i = 0; i < N_CH; i++) begin
                    state[i] <= ST_IDLE;
                    cnt[i]   <= '0;
                    rem[i]   <= '0;
                end
                pulse_out <= '0;
            end else if (accept) begin
                for (int i = 0; i < N_CH; i++) begin
                    act_width[i]  <= sh_width[i];
                    act_period[i] <= sh_period[i];
                    if (enable[i] && (sh_width[i] != '0)) begin
                        state[i] <= ST_WAIT;
                        cnt[i]   <= sh_delay[i];
                        rem[i]   <= (sh_count[i] == '0) ? '0 : (sh_count[i] - RW'(1));
                    end
                end
            end else begin
                done <= busy && ((running & ~finishing) == '0);
                for (int i = 0; i < N_CH; i++) begin
                    case (state[i])
                        ST_WAIT: begin
                            if (cnt[i] == '0) begin
                                state[i]     <= ST_HIGH;
                                pulse_out[i] <= 1'b1;
                                cnt[i]       <= act_width[i] - CW'(1);
                            end else begin
                                cnt[i] <= cnt[i] - CW'(1);
                            end
                        end
                        ST_HIGH: begin
                            if (cnt[i] == '0) begin
                                pulse_out[i] <= 1'b0;
                                if (rem[i] == '0) begin
                                    state[i] <= ST_IDLE;
                                end else begin
                                    state[i] <= ST_LOW;
                                    rem[i]   <= rem[i] - RW'(1);
                                    cnt[i]   <= low_len[i] - CW'(1);
                                end
                            end else begin
                                cnt[i] <= cnt[i] - CW'(1);
                            end
                        end
                        ST_LOW: begin
                            if (cnt[i] == '0) begin
                                state[i]     <= ST_HIGH;
                                pulse_out[i] <= 1'b1;
                                cnt[i]       <= act_width[i] - CW'(1);
                            end else begin
                                cnt[i] <= cnt[i] - CW'(1);
                            end
                        end
                        default: begin
                            state[i]     <= ST_IDLE;
                            pulse_out[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_burst_pulser.sv
// Directed, self-checking bench for burst_pulser.
// Inputs change 1 time unit after each rising edge.
// Outputs are sampled at that same point, well away from the next edge.
module tb_burst_pulser;

    localparam int N_CH = 8;
    localparam int CW   = 32;
    localparam int RW   = 16;
    localparam int CHW  = 3;

    localparam logic [2:0] R_DELAY  = 3'd0;
    localparam logic [2:0] R_WIDTH  = 3'd1;
    localparam logic [2:0] R_PERIOD = 3'd2;
    localparam logic [2:0] R_COUNT  = 3'd3;
    localparam logic [2:0] R_ENABLE = 3'd4;
    localparam logic [2:0] R_STATUS = 3'd5;
    localparam logic [2:0] R_MISSED = 3'd6;

    logic            clk     = 1'b0;
    logic            rst     = 1'b0;
    logic            trig_in = 1'b0;
    logic            abort   = 1'b0;
    logic [N_CH-1:0] pulse_out;
    logic            busy;
    logic            done;

    int errors = 0;
    int checks = 0;

    burst_pulser_if #(.N_CH(N_CH), .CW(CW), .CHW(CHW)) bus ();

    burst_pulser #(.N_CH(N_CH), .CW(CW), .RW(RW), .CHW(CHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg       (bus),
        .trig_in   (trig_in),
        .abort     (abort),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cfg_write(input logic [CHW-1:0] ch, input logic [2:0] sel, input logic [31:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = ch;
        bus.cfg_reg   = sel;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic cfg_check(input string tag, input logic [CHW-1:0] ch, input logic [2:0] sel, input logic [31:0] expected);
        bus.cfg_ch  = ch;
        bus.cfg_reg = sel;
        #1;
        check_output(tag, bus.cfg_rdata, expected);
    endtask

    task automatic program_ch(input logic [CHW-1:0] ch, input logic [31:0] dly, input logic [31:0] wid,
                              input logic [31:0] per, input logic [31:0] cnt);
        cfg_write(ch, R_DELAY, dly);
        cfg_write(ch, R_WIDTH, wid);
        cfg_write(ch, R_PERIOD, per);
        cfg_write(ch, R_COUNT, cnt);
    endtask

    // Trigger once. Then, for each sample k taken after edge E0+k, compare the outputs against
    // the expected bit masks. When wr_mid is set, ch1 DELAY is rewritten to 7 on edge E0+1.
    task automatic run_burst(input string tag, input int nk, input logic [31:0] pmask,
                             input logic [31:0] bmask, input logic [31:0] dmask,
                             input logic [N_CH-1:0] pval, input bit wr_mid);
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        for (int k = 0; k < nk; k++) begin
            if (k > 0) tick();
            if (wr_mid && k == 1) bus.cfg_we = 1'b0;
            check_output($sformatf("%s_pulse_k%0d", tag, k), 32'(pulse_out), pmask[k] ? 32'(pval) : 32'h0);
            check_output($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'(bmask[k]));
            check_output($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'(dmask[k]));
            if (wr_mid && k == 0) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_ch    = 3'd1;
                bus.cfg_reg   = R_DELAY;
                bus.cfg_wdata = 32'd7;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check_output({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_reg   = '0;
        bus.cfg_wdata = '0;

        // Reset: the outputs are quiet and the shadow registers hold their reset values.
        #22 rst = 1'b1;
        tick();
        check_output("rst_pulse", 32'(pulse_out), 32'h0);
        check_output("rst_busy", 32'(busy), 32'h0);
        check_output("rst_done", 32'(done), 32'h0);
        cfg_check("rst_delay", 3'd0, R_DELAY, 32'd100);
        cfg_check("rst_width", 3'd0, R_WIDTH, 32'd100);
        cfg_check("rst_period", 3'd0, R_PERIOD, 32'd200);
        cfg_check("rst_count", 3'd0, R_COUNT, 32'd1);
        cfg_check("rst_enable", 3'd0, R_ENABLE, 32'd0);
        cfg_check("rst_missed", 3'd0, R_MISSED, 32'd0);
        cfg_check("rst_status", 3'd0, R_STATUS, 32'd0);
        cfg_check("rst_width_ch7", 3'd7, R_WIDTH, 32'd100);

        // ch0: DELAY 0, WIDTH 3, PERIOD 5, COUNT 3.
        program_ch(3'd0, 32'd0, 32'd3, 32'd5, 32'd3);
        cfg_write(3'd0, R_ENABLE, 32'h01);
        run_burst("ch0", 16, 32'h39CE, 32'h3FFF, 32'h4000, 8'h01, 1'b0);

        // ch1: WIDTH 4, PERIOD 2, so the effective period clamps to 5 and each low gap is 1 cycle.
        program_ch(3'd1, 32'd0, 32'd4, 32'd2, 32'd2);
        cfg_write(3'd0, R_ENABLE, 32'h02);
        run_burst("clamp", 12, 32'h03DE, 32'h03FF, 32'h0400, 8'h02, 1'b0);

        // Two triggers while busy: the burst must not restart, and MISSED counts them.
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        tick();
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        tick();
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        check_output("miss_pulse_k4", 32'(pulse_out), 32'h02);
        tick();
        check_output("miss_pulse_k5", 32'(pulse_out), 32'h00);
        tick();
        check_output("miss_pulse_k6", 32'(pulse_out), 32'h02);
        cfg_check("miss_count", 3'd0, R_MISSED, 32'd2);
        wait_idle("miss");
        cfg_write(3'd0, R_MISSED, 32'hFFFF_FFFF);
        cfg_check("miss_cleared", 3'd0, R_MISSED, 32'd0);

        // A mid-burst DELAY write does not affect the running burst. The next burst uses it.
        cfg_write(3'd1, R_DELAY, 32'd2);
        run_burst("mid", 14, 32'h0F78, 32'h0FFF, 32'h1000, 8'h02, 1'b1);
        cfg_check("mid_shadow", 3'd1, R_DELAY, 32'd7);
        run_burst("next", 19, 32'h0001_EF00, 32'h0001_FFFF, 32'h0002_0000, 8'h02, 1'b0);

        // Two channels with equal settings stay cycle-aligned.
        program_ch(3'd0, 32'd7, 32'd4, 32'd2, 32'd2);
        cfg_write(3'd0, R_ENABLE, 32'h03);
        run_burst("align", 19, 32'h0001_EF00, 32'h0001_FFFF, 32'h0002_0000, 8'h03, 1'b0);

        // WIDTH 0 prevents the channel from starting.
        cfg_write(3'd1, R_WIDTH, 32'd0);
        cfg_write(3'd0, R_ENABLE, 32'h02);
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        check_output("w0_busy", 32'(busy), 32'h0);
        tick();
        check_output("w0_pulse", 32'(pulse_out), 32'h0);
        check_output("w0_done", 32'(done), 32'h0);

        // Abort during HIGH: outputs drop on the next edge, and done never fires.
        program_ch(3'd1, 32'd0, 32'd4, 32'd2, 32'd2);
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        tick();
        tick();
        check_output("abort_pre_pulse", 32'(pulse_out), 32'h02);
        abort = 1'b1; tick(); abort = 1'b0;
        check_output("abort_pulse", 32'(pulse_out), 32'h0);
        check_output("abort_busy", 32'(busy), 32'h0);
        check_output("abort_done", 32'(done), 32'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_output($sformatf("abort_nodone_%0d", k), 32'(done), 32'h0);
        end

        // Abort together with a trigger: abort wins and nothing starts.
        abort = 1'b1; trig_in = 1'b1; tick(); abort = 1'b0; trig_in = 1'b0;
        check_output("abtrig_busy", 32'(busy), 32'h0);
        tick();
        check_output("abtrig_pulse", 32'(pulse_out), 32'h0);
        cfg_check("abtrig_missed", 3'd0, R_MISSED, 32'd0);

        // Asynchronous reset in the middle of a burst.
        trig_in = 1'b1; tick(); trig_in = 1'b0;
        tick();
        tick();
        check_output("arst_pre_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check_output("arst_pulse", 32'(pulse_out), 32'h0);
        check_output("arst_busy", 32'(busy), 32'h0);
        cfg_check("arst_width", 3'd1, R_WIDTH, 32'd100);
        cfg_check("arst_enable", 3'd0, R_ENABLE, 32'd0);
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
